axi4_master_agent: RTL and testbench
====================================

AXI4_MASTER_AGENT -- requirements
Module: axi4_master_agent

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, handshake watchdog limit.
REQ-005 Ports:
  clk  in  1  single clock; all logic on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  axi  axi4_if.master  -  AXI4 initiator port.
  cmd_valid  in  1  command request.
  cmd_ready  out  1  command accepted when high with cmd_valid.
  cmd_write  in  1  1=write, 0=read.
  cmd_id  in  ID_WIDTH  AxID.
  cmd_addr  in  ADDR_WIDTH  AxADDR.
  cmd_len  in  8  AxLEN.
  cmd_size  in  3  AxSIZE.
  cmd_burst  in  2  AxBURST.
  cmd_seed  in  DATA_WIDTH  data pattern seed.
  done_valid  out  1  one-cycle completion pulse.
  done_resp  out  2  worst response of transaction.
  done_mismatch  out  1  read data/RLAST/ID check failed.
  done_timeout  out  1  watchdog expired during transaction.
  read_count, write_count, error_count  out  32 each  statistics.

Function
REQ-006 SHALL support one outstanding transaction; cmd_ready high only in IDLE.
REQ-007 FSM states: IDLE, AW, W, B, AR, R, DONE.
REQ-008 IDLE: on cmd_valid&&cmd_ready latch all cmd_* fields; go AW if cmd_write else AR.
REQ-009 AW: awvalid=1 with latched fields; hold stable until awready; then W. awvalid first high the cycle after command acceptance.
REQ-010 W: wvalid=1, wdata=seed+beat (mod 2^DATA_WIDTH), wstrb all ones, wlast=(beat==len); beat increments on wready; after last-beat handshake go B. wvalid never asserted in AW.
REQ-011 B: bready=1; on bvalid go DONE; done_resp=bresp; bid!=latched id sets mismatch.
REQ-012 AR: arvalid=1, held until arready; then R.
REQ-013 R: rready=1; per beat compare rdata to seed+beat, rid to latched id, rlast to (beat==len); any difference sets sticky mismatch; done_resp holds the maximum rresp seen; leave on rlast or on beat==len.
REQ-014 DONE: done_valid=1 for exactly one cycle with done_* stable; next cycle IDLE. done_* hold value until next DONE.
REQ-015 Unused AxLOCK, AxPROT, AxQOS, AxREGION, user signals SHALL drive 0; AxCACHE SHALL drive 4'b0011.
REQ-016 Watchdog: counter clears on every state change; increments each cycle in AW/W/B/AR/R; at TIMEOUT_CYCLES sets sticky done_timeout and saturates; it SHALL NOT abort or drop any VALID.
REQ-017 write_count +1 at B handshake; read_count +1 at R last beat; error_count +1 per DONE with resp!=OKAY, mismatch or timeout; all saturate at 32'hFFFF_FFFF.
REQ-018 Burst legality (WRAP length, 4KB boundary) is caller responsibility; fields pass through unchanged.

Reset
REQ-019 On rst_n low, immediately: FSM=IDLE; awvalid, wvalid, wlast, bready, arvalid, rready, done_valid, done_resp, done_mismatch, done_timeout, all counters = 0; cmd_ready = 0 during reset and 1 from the first cycle after deassertion.
REQ-020 Reset mid-transaction SHALL abandon it with no DONE pulse or count update.

Structure
REQ-021 axi4_resp_t, axi4_burst_t and AXI constants SHALL come from the shared axi4_defines package; FSM state enum stays local.
REQ-022 Watchdog SHALL be sub-module axi4_master_timeout_wdog (clear, enable, expired).

Verification
REQ-023 Write INCR len=3 size=3 addr=0x100 seed=0x10, slave always ready -> wdata 0x10..0x13, wlast on 4th beat, done_resp=OKAY, write_count=1.
REQ-024 Read same region, slave returns 0x10..0x13 -> done_mismatch=0, read_count=1; corrupt beat 2 to 0xFF -> done_mismatch=1, error_count=1.
REQ-025 Slave holds awready low 20 cycles -> awvalid and all AW fields stable for 20 cycles, no wvalid before AW handshake.
REQ-026 TIMEOUT_CYCLES=16, arready low 40 cycles -> arvalid stays high, done_timeout=1 at DONE, error_count+1.
REQ-027 bresp=SLVERR -> done_resp=2'b10, error_count+1; rlast early on beat 1 of len=3 -> mismatch=1, DONE next cycle.
REQ-028 rst_n low during W beat 2 -> wvalid=0 immediately, no done_valid, counters 0, new command accepted after release.

Source files
------------

// File: rtl/axi4_defines.sv
// rtl/axi4_defines.sv - shared AXI4 response/burst types and protocol constants
package axi4_defines;

   typedef enum logic [1:0] {
      AXI_RESP_OKAY   = 2'b00,
      AXI_RESP_EXOKAY = 2'b01,
      AXI_RESP_SLVERR = 2'b10,
      AXI_RESP_DECERR = 2'b11
   } axi4_resp_t;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'b00,
      AXI_BURST_INCR  = 2'b01,
      AXI_BURST_WRAP  = 2'b10,
      AXI_BURST_RSVD  = 2'b11
   } axi4_burst_t;

   localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
   localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
   localparam logic [3:0] AXI_QOS_DEFAULT   = 4'b0000;

   // Numerically larger responses are the more severe ones.
   function automatic axi4_resp_t axi4_resp_max(input axi4_resp_t a, input axi4_resp_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi4_if.sv
// rtl/axi4_if.sv - AXI4 five-channel bundle with master/slave views
interface axi4_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int USER_WIDTH = 1
);
   import axi4_defines::*;

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   axi4_burst_t           awburst;
   logic                  awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic [3:0]            awqos;
   logic [3:0]            awregion;
   logic [USER_WIDTH-1:0] awuser;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic [USER_WIDTH-1:0] wuser;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   axi4_resp_t            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   axi4_burst_t           arburst;
   logic                  arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic [3:0]            arqos;
   logic [3:0]            arregion;
   logic [USER_WIDTH-1:0] aruser;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   axi4_resp_t            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wuser, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wuser, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi4_master_timeout_wdog.sv
// rtl/axi4_master_timeout_wdog.sv - saturating handshake watchdog counter
module axi4_master_timeout_wdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && cnt != LIMIT)
         cnt <= cnt + 1'b1;
   end

   assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/axi4_master_agent.sv
// rtl/axi4_master_agent.sv - single-outstanding AXI4 traffic master with data-pattern checking
module axi4_master_agent
   import axi4_defines::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int ID_WIDTH       = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   axi4_if.master                axi,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [2:0]            cmd_size,
   input  logic [1:0]            cmd_burst,
   input  logic [DATA_WIDTH-1:0] cmd_seed,
   output logic                  done_valid,
   output logic [1:0]            done_resp,
   output logic                  done_mismatch,
   output logic                  done_timeout,
   output logic [31:0]           read_count,
   output logic [31:0]           write_count,
   output logic [31:0]           error_count
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

   state_t                state, state_nxt;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   axi4_burst_t           burst_q;
   logic [DATA_WIDTH-1:0] seed_q;
   logic                  write_q;
   logic [7:0]            beat;
   axi4_resp_t            resp_acc, resp_nxt;
   logic                  mm_acc, mm_nxt, to_acc, to_nxt;
   logic                  accept, last_beat, wd_enable, wd_expired;
   logic [DATA_WIDTH-1:0] expect_data;

   assign accept      = cmd_valid && cmd_ready;
   assign last_beat   = (beat == len_q);
   assign expect_data = seed_q + DATA_WIDTH'(beat);

   axi4_master_timeout_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_nxt != state),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = cmd_write ? S_AW : S_AR;
         S_AW:   if (axi.awready) state_nxt = S_W;
         S_W:    if (axi.wready && last_beat) state_nxt = S_B;
         S_B:    if (axi.bvalid) state_nxt = S_DONE;
         S_AR:   if (axi.arready) state_nxt = S_R;
         S_R:    if (axi.rvalid && (axi.rlast || last_beat)) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // cmd_ready is gated by rst_n so it reads low for the whole reset window.
   always_comb begin
      cmd_ready   = (state == S_IDLE) && rst_n;
      axi.awvalid = (state == S_AW);
      axi.wvalid  = (state == S_W);
      axi.wlast   = (state == S_W) && last_beat;
      axi.bready  = (state == S_B);
      axi.arvalid = (state == S_AR);
      axi.rready  = (state == S_R);
      wd_enable   = (state == S_AW) || (state == S_W) || (state == S_B) ||
                    (state == S_AR) || (state == S_R);
   end

   assign axi.awid     = id_q;
   assign axi.awaddr   = addr_q;
   assign axi.awlen    = len_q;
   assign axi.awsize   = size_q;
   assign axi.awburst  = burst_q;
   assign axi.awlock   = 1'b0;
   assign axi.awcache  = AXI_CACHE_DEFAULT;
   assign axi.awprot   = AXI_PROT_DEFAULT;
   assign axi.awqos    = AXI_QOS_DEFAULT;
   assign axi.awregion = 4'b0000;
   assign axi.awuser   = '0;
   assign axi.wdata    = expect_data;
   assign axi.wstrb    = {STRB_WIDTH{1'b1}};
   assign axi.wuser    = '0;
   assign axi.arid     = id_q;
   assign axi.araddr   = addr_q;
   assign axi.arlen    = len_q;
   assign axi.arsize   = size_q;
   assign axi.arburst  = burst_q;
   assign axi.arlock   = 1'b0;
   assign axi.arcache  = AXI_CACHE_DEFAULT;
   assign axi.arprot   = AXI_PROT_DEFAULT;
   assign axi.arqos    = AXI_QOS_DEFAULT;
   assign axi.arregion = 4'b0000;
   assign axi.aruser   = '0;

   // Status as it will stand after this cycle, so DONE can latch it directly.
   always_comb begin
      resp_nxt = resp_acc;
      mm_nxt   = mm_acc;
      to_nxt   = to_acc | wd_expired;
      if (state == S_B && axi.bvalid) begin
         resp_nxt = axi.bresp;
         if (axi.bid != id_q) mm_nxt = 1'b1;
      end
      if (state == S_R && axi.rvalid) begin
         resp_nxt = axi4_resp_max(resp_acc, axi.rresp);
         if (axi.rdata != expect_data || axi.rid != id_q || axi.rlast != last_beat)
            mm_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q          <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         size_q        <= '0;
         burst_q       <= AXI_BURST_FIXED;
         seed_q        <= '0;
         write_q       <= 1'b0;
         beat          <= '0;
         resp_acc      <= AXI_RESP_OKAY;
         mm_acc        <= 1'b0;
         to_acc        <= 1'b0;
         done_valid    <= 1'b0;
         done_resp     <= 2'b00;
         done_mismatch <= 1'b0;
         done_timeout  <= 1'b0;
         read_count    <= '0;
         write_count   <= '0;
         error_count   <= '0;
      end else begin
         if (accept) begin
            id_q     <= cmd_id;
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            size_q   <= cmd_size;
            burst_q  <= axi4_burst_t'(cmd_burst);
            seed_q   <= cmd_seed;
            write_q  <= cmd_write;
            beat     <= '0;
            resp_acc <= AXI_RESP_OKAY;
            mm_acc   <= 1'b0;
            to_acc   <= 1'b0;
         end else begin
            resp_acc <= resp_nxt;
            mm_acc   <= mm_nxt;
            to_acc   <= to_nxt;
            if ((state == S_W && axi.wready) || (state == S_R && axi.rvalid))
               beat <= beat + 8'd1;
         end

         done_valid <= (state_nxt == S_DONE);
         if (state_nxt == S_DONE) begin
            done_resp     <= resp_nxt;
            done_mismatch <= mm_nxt;
            done_timeout  <= to_nxt;
            if ((resp_nxt != AXI_RESP_OKAY || mm_nxt || to_nxt) && error_count != 32'hFFFF_FFFF)
               error_count <= error_count + 32'd1;
         end

         if (state == S_B && axi.bvalid && write_q && write_count != 32'hFFFF_FFFF)
            write_count <= write_count + 32'd1;
         if (state == S_R && axi.rvalid && (axi.rlast || last_beat) && read_count != 32'hFFFF_FFFF)
            read_count <= read_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_axi4_master_agent.sv
// tb/tb_axi4_master_agent.sv - randomized self-checking bench for axi4_master_agent
module tb_axi4_master_agent;
   import axi4_defines::*;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

   logic          cmd_valid, cmd_ready, cmd_write;
   logic [IW-1:0] cmd_id;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_len;
   logic [2:0]    cmd_size;
   logic [1:0]    cmd_burst;
   logic [DW-1:0] cmd_seed;
   logic          done_valid, done_mismatch, done_timeout;
   logic [1:0]    done_resp;
   logic [31:0]   read_count, write_count, error_count;

   axi4_master_agent #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .axi(axi),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .cmd_seed(cmd_seed), .done_valid(done_valid), .done_resp(done_resp),
      .done_mismatch(done_mismatch), .done_timeout(done_timeout),
      .read_count(read_count), .write_count(write_count), .error_count(error_count)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int exp_wr   = 0;
   int exp_rd   = 0;
   int exp_err  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [IW-1:0] flip_id(input logic [IW-1:0] id);
      return {id[IW-1:1], ~id[0]};
   endfunction

   task automatic issue(input logic wr, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                        input logic [DW-1:0] seed);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = addr;
      cmd_len = len; cmd_size = size; cmd_burst = burst; cmd_seed = seed;
      while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("cmd_ready", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Model: the DONE record follows from what the slave did, at transaction level.
   task automatic check_done(input string tag, input logic [1:0] resp, input logic mm, input logic tout);
      if (resp != 2'b00 || mm || tout) exp_err++;
      check({tag, "_done_valid"}, done_valid, 1'b1);
      check({tag, "_done_resp"}, done_resp, resp);
      check({tag, "_done_mismatch"}, done_mismatch, mm);
      check({tag, "_done_timeout"}, done_timeout, tout);
      check({tag, "_write_count"}, write_count, exp_wr);
      check({tag, "_read_count"}, read_count, exp_rd);
      check({tag, "_error_count"}, error_count, exp_err);
      @(negedge clk);
      check({tag, "_done_pulse"}, done_valid, 1'b0);
      check({tag, "_done_hold"}, {done_resp, done_mismatch, done_timeout}, {resp, mm, tout});
   endtask

   task automatic run_write(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input logic [DW-1:0] seed, input int aw_stall, input int w_stall,
                            input int b_stall, input logic [1:0] bresp_v, input logic bad_bid);
      logic ok_aw, ok_w, tout;
      int n;
      tout = (aw_stall + 1 > TO) || ((int'(len) + 1) * (w_stall + 1) > TO) || (b_stall + 1 > TO);
      issue(1'b1, id, addr, len, size, burst, seed);
      check({tag, "_aw_first"}, {axi.awvalid, axi.wvalid}, 2'b10);
      ok_aw = 1'b1;
      for (int i = 0; i < aw_stall; i++) begin
         ok_aw = ok_aw & axi.awvalid & !axi.wvalid & (axi.awaddr == addr) & (axi.awlen == len) &
                 (axi.awid == id) & (axi.awsize == size) & (axi.awburst == burst);
         @(negedge clk);
      end
      check({tag, "_aw_stable"}, ok_aw, 1'b1);
      check({tag, "_aw_fields"}, {axi.awid, axi.awaddr, axi.awlen, axi.awsize, 2'(axi.awburst)},
            {id, addr, len, size, burst});
      check({tag, "_aw_tieoff"}, {axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion, axi.awuser},
            {1'b0, 4'b0011, 3'b000, 4'b0000, 4'b0000, 1'b0});
      axi.awready = 1'b1; @(negedge clk); axi.awready = 1'b0;
      ok_w = 1'b1;
      for (int b = 0; b <= int'(len); b++) begin
         n = 0;
         while (axi.wvalid !== 1'b1 && n < 32) begin @(negedge clk); n++; end
         for (int i = 0; i < w_stall; i++) begin ok_w = ok_w & axi.wvalid; @(negedge clk); end
         check({tag, "_wdata"}, axi.wdata, seed + DW'(b));
         check({tag, "_wlast"}, {axi.wvalid, axi.wlast, axi.wstrb}, {1'b1, (b == int'(len)), 8'hFF});
         axi.wready = 1'b1; @(negedge clk); axi.wready = 1'b0;
      end
      check({tag, "_w_held"}, ok_w, 1'b1);
      check({tag, "_b_ready"}, {axi.bready, axi.wvalid}, 2'b10);
      repeat (b_stall) @(negedge clk);
      axi.bvalid = 1'b1; axi.bresp = axi4_resp_t'(bresp_v);
      axi.bid = bad_bid ? flip_id(id) : id;
      @(negedge clk);
      axi.bvalid = 1'b0;
      exp_wr++;
      check_done(tag, bresp_v, bad_bid, tout);
   endtask

   task automatic run_read(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [DW-1:0] seed, input int ar_stall, input int r_stall,
                           input int corrupt_beat, input logic bad_rid, input int early_last,
                           input logic drop_last, input logic rand_resp);
      int fin;
      logic ok_ar, ok_r, mm, tout;
      logic [1:0] worst, rr;
      fin  = (early_last >= 0) ? early_last : int'(len);
      tout = (ar_stall + 1 > TO) || ((fin + 1) * (r_stall + 1) > TO);
      mm   = bad_rid || (early_last >= 0) || drop_last || (corrupt_beat >= 0 && corrupt_beat <= fin);
      worst = 2'b00;
      issue(1'b0, id, addr, len, size, burst, seed);
      check({tag, "_ar_first"}, {axi.arvalid, axi.rready, axi.awvalid}, 3'b100);
      ok_ar = 1'b1;
      for (int i = 0; i < ar_stall; i++) begin
         ok_ar = ok_ar & axi.arvalid & !axi.rready & (axi.araddr == addr) & (axi.arlen == len) &
                 (axi.arid == id);
         @(negedge clk);
      end
      check({tag, "_ar_stable"}, ok_ar, 1'b1);
      check({tag, "_ar_fields"}, {axi.arid, axi.araddr, axi.arlen, axi.arsize, 2'(axi.arburst), axi.arcache},
            {id, addr, len, size, burst, 4'b0011});
      axi.arready = 1'b1; @(negedge clk); axi.arready = 1'b0;
      ok_r = 1'b1;
      for (int b = 0; b <= fin; b++) begin
         for (int i = 0; i < r_stall; i++) begin ok_r = ok_r & axi.rready; @(negedge clk); end
         ok_r = ok_r & axi.rready;
         rr = rand_resp ? 2'($urandom_range(0, 3)) : 2'b00;
         if (rr > worst) worst = rr;
         axi.rvalid = 1'b1;
         axi.rdata  = (b == corrupt_beat) ? ((seed + DW'(b)) ^ 64'hED) : (seed + DW'(b));
         axi.rid    = (bad_rid && b == 0) ? flip_id(id) : id;
         axi.rlast  = (b == early_last) || (b == int'(len) && !drop_last);
         axi.rresp  = axi4_resp_t'(rr);
         @(negedge clk);
         axi.rvalid = 1'b0; axi.rlast = 1'b0;
      end
      check({tag, "_r_ready"}, ok_r, 1'b1);
      exp_rd++;
      check_done(tag, worst, mm, tout);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [IW-1:0] r_id;
      logic [AW-1:0] r_addr;
      logic [7:0]    r_len;
      logic [DW-1:0] r_seed;
      int            r_early, r_corrupt;

      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0;
      cmd_len = '0; cmd_size = '0; cmd_burst = '0; cmd_seed = '0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
      axi.bvalid = 1'b0; axi.bresp = AXI_RESP_OKAY; axi.bid = '0;
      axi.rvalid = 1'b0; axi.rdata = '0; axi.rid = '0; axi.rresp = AXI_RESP_OKAY; axi.rlast = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_valids", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready}, 6'b0);
      check("rst_done", {done_valid, done_resp, done_mismatch, done_timeout}, 5'b0);
      check("rst_counts", {read_count, write_count}, 64'h0);
      rst_n = 1'b1;
      #1 check("rel_cmd_ready", cmd_ready, 1'b1);
      @(negedge clk);

      run_write("wr_basic", 4'h3, 32'h100, 8'd3, 3'd3, 2'b01, 64'h10, 0, 0, 0, 2'b00, 1'b0);
      run_read("rd_basic", 4'h3, 32'h100, 8'd3, 3'd3, 2'b01, 64'h10, 0, 0, -1, 1'b0, -1, 1'b0, 1'b0);
      run_read("rd_corrupt", 4'h3, 32'h100, 8'd3, 3'd3, 2'b01, 64'h10, 0, 0, 2, 1'b0, -1, 1'b0, 1'b0);
      run_write("wr_aw_hold", 4'h5, 32'h2000, 8'd1, 3'd2, 2'b01, 64'hABCD, 20, 0, 0, 2'b00, 1'b0);
      run_read("rd_ar_tmo", 4'h6, 32'h3000, 8'd1, 3'd3, 2'b01, 64'h77, 40, 0, -1, 1'b0, -1, 1'b0, 1'b0);
      run_write("wr_w_tmo", 4'h2, 32'h400, 8'd7, 3'd3, 2'b01, 64'h1, 0, 3, 0, 2'b00, 1'b0);
      run_read("rd_early", 4'h9, 32'h500, 8'd3, 3'd3, 2'b01, 64'h40, 0, 0, -1, 1'b0, 1, 1'b0, 1'b0);
      run_read("rd_nolast", 4'h4, 32'h600, 8'd2, 3'd3, 2'b10, 64'h80, 0, 1, -1, 1'b0, -1, 1'b1, 1'b0);
      run_write("wr_badbid", 4'hA, 32'h700, 8'd0, 3'd0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 2, 2'b00, 1'b1);

      for (int t = 0; t < 14; t++) begin
         r_id = IW'($urandom); r_addr = $urandom; r_len = 8'($urandom_range(0, 3));
         r_seed = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) begin
            run_write("wr_rand", r_id, r_addr, r_len, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                      r_seed, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                      ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                      $urandom_range(0, 5) == 0);
         end else begin
            r_early   = (r_len > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(r_len) - 1)) : -1;
            r_corrupt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_read("rd_rand", r_id, r_addr, r_len, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                     r_seed, $urandom_range(0, 2), $urandom_range(0, 2), r_corrupt,
                     $urandom_range(0, 5) == 0, r_early, $urandom_range(0, 5) == 0, 1'b1);
         end
      end

      run_write("wr_slverr", 4'h1, 32'h800, 8'd1, 3'd3, 2'b01, 64'h5, 0, 0, 0, 2'b10, 1'b0);

      issue(1'b1, 4'h7, 32'h900, 8'd3, 3'd3, 2'b01, 64'h200);
      axi.awready = 1'b1; @(negedge clk); axi.awready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         axi.wready = 1'b1; @(negedge clk); axi.wready = 1'b0;
      end
      check("rst_mid_w2", {axi.wvalid, axi.wdata}, {1'b1, 64'h202});
      #2 rst_n = 1'b0;
      #1;
      exp_wr = 0; exp_rd = 0; exp_err = 0;
      check("rst_mid_valids", {axi.wvalid, axi.wlast, axi.awvalid, axi.bready, cmd_ready}, 5'b0);
      check("rst_mid_done", {done_valid, done_resp, done_mismatch, done_timeout}, 5'b0);
      check("rst_mid_wcnt", write_count, exp_wr);
      check("rst_mid_rcnt", read_count, exp_rd);
      check("rst_mid_ecnt", error_count, exp_err);
      @(negedge clk);
      check("rst_hold_done", done_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rel_state", {cmd_ready, done_valid, axi.wvalid}, 3'b100);
      run_write("wr_after_rst", 4'h8, 32'hA00, 8'd2, 3'd3, 2'b01, 64'h1000, 0, 1, 0, 2'b00, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
